// File: rtl/xunitm_sched_ctrl.sv
// Sequencer for the SHA-256 message-schedule unit (xunitM).
// Runs a job of nblk 512-bit blocks. For each block it arms the unit, streams the
// 16 message words through to the unit and downstream, then steps the unit 48 times
// and forwards W[16..63]. The unit is only stepped when its result can be
// accepted, so downstream backpressure stalls the schedule without losing words.
//
// Ports
//   clk, rst             clock, synchronous active-high reset (shared with the unit)
//   start, abort, nblk   job control; nblk sampled on start
//   busy, done           job in progress / 1-cycle completion pulse
//   msg_valid/ready/data message word input stream
//   w_valid/ready/data   schedule word output stream, w_idx = t, w_last on final word
//   u_run, u_running     unit arm / unit step enable (never both high)
//   u_in0, u_delay0      unit data input / unit delay configuration (tied to 0)
//   u_out0               unit schedule output, held while u_running is low
module xunitm_sched_ctrl #(
  parameter int unsigned DELAY_W = 32,
  parameter int unsigned DATA_W  = 32,  // must be 32 for SHA-256
  parameter int unsigned BLK_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [BLK_W-1:0]   nblk,
  output logic               busy,
  output logic               done,
  input  logic               msg_valid,
  output logic               msg_ready,
  input  logic [DATA_W-1:0]  msg_data,
  output logic               w_valid,
  input  logic               w_ready,
  output logic [DATA_W-1:0]  w_data,
  output logic [5:0]         w_idx,
  output logic               w_last,
  output logic               u_run,
  output logic               u_running,
  output logic [DATA_W-1:0]  u_in0,
  output logic [DELAY_W-1:0] u_delay0,
  input  logic [DATA_W-1:0]  u_out0
);

  typedef enum logic [2:0] {StIdle, StArm, StLoad, StExpand, StFin} state_e;

  localparam logic [5:0] LastLoadIdx = 6'd15;
  localparam logic [5:0] LastIdx     = 6'd63;
  localparam logic [5:0] NumSteps    = 6'd48;

  state_e           state_q, state_d;
  logic [BLK_W-1:0] blk_left_q, blk_left_d;
  logic [5:0]       t_q, t_d;      // word index within the block
  logic [5:0]       iss_q, iss_d;  // expansion steps issued to the unit
  logic             ov_q, ov_d;    // unit output holds a word not yet accepted
  logic             step;
  logic             w_hs;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      blk_left_q <= '0;
      t_q        <= '0;
      iss_q      <= '0;
      ov_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      blk_left_q <= blk_left_d;
      t_q        <= t_d;
      iss_q      <= iss_d;
      ov_q       <= ov_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    blk_left_d = blk_left_q;
    t_d        = t_q;
    iss_d      = iss_q;
    ov_d       = ov_q;
    busy       = 1'b0;
    done       = 1'b0;
    msg_ready  = 1'b0;
    w_valid    = 1'b0;
    w_data     = '0;
    w_last     = 1'b0;
    u_run      = 1'b0;
    u_running  = 1'b0;
    u_in0      = '0;
    step       = 1'b0;
    w_hs       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          blk_left_d = nblk;
          t_d        = '0;
          iss_d      = '0;
          ov_d       = 1'b0;
          state_d    = (nblk == '0) ? StFin : StArm;
        end
      end
      StArm: begin
        busy    = 1'b1;
        u_run   = 1'b1;
        t_d     = '0;
        iss_d   = '0;
        ov_d    = 1'b0;
        state_d = StLoad;
      end
      StLoad: begin
        // Message words pass straight through; the unit steps once per accepted word.
        busy      = 1'b1;
        w_valid   = msg_valid;
        w_data    = msg_data;
        u_in0     = msg_data;
        msg_ready = w_ready;
        u_running = msg_valid & w_ready;
        if (u_running) begin
          t_d = t_q + 6'd1;
          if (t_q == LastLoadIdx) begin
            state_d = StExpand;
          end
        end
      end
      StExpand: begin
        busy = 1'b1;
        // Step only when the current output slot is free or being drained this cycle.
        step      = (iss_q < NumSteps) & (~ov_q | w_ready);
        u_running = step;
        iss_d     = iss_q + {5'd0, step};
        ov_d      = step ? 1'b1 : (w_ready ? 1'b0 : ov_q);
        w_valid   = ov_q;
        w_data    = u_out0;
        w_hs      = ov_q & w_ready;
        if (w_hs) begin
          if (t_q == LastIdx) begin
            t_d        = '0;
            blk_left_d = blk_left_q - BLK_W'(1);
            state_d    = (blk_left_q == BLK_W'(1)) ? StFin : StArm;
          end else begin
            t_d = t_q + 6'd1;
          end
        end
      end
      StFin: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    w_last = w_valid & (t_q == LastIdx) & (blk_left_q == BLK_W'(1));

    // The unit window is left as is; the next ARM reinitialises it.
    if (abort) begin
      state_d    = StIdle;
      blk_left_d = '0;
      t_d        = '0;
      iss_d      = '0;
      ov_d       = 1'b0;
    end
  end

  assign w_idx    = t_q;
  assign u_delay0 = '0;

endmodule

// File: tb/tb_xunitm_sched_ctrl.sv
module tb_xunitm_sched_ctrl;

  localparam int unsigned DELAY_W = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned BLK_W   = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               abort;
  logic [BLK_W-1:0]   nblk;
  logic               busy;
  logic               done;
  logic               msg_valid;
  logic               msg_ready;
  logic [DATA_W-1:0]  msg_data;
  logic               w_valid;
  logic               w_ready;
  logic [DATA_W-1:0]  w_data;
  logic [5:0]         w_idx;
  logic               w_last;
  logic               u_run;
  logic               u_running;
  logic [DATA_W-1:0]  u_in0;
  logic [DELAY_W-1:0] u_delay0;
  logic [DATA_W-1:0]  u_out0;

  always #5 clk = ~clk;

  xunitm_sched_ctrl #(
    .DELAY_W(DELAY_W),
    .DATA_W (DATA_W),
    .BLK_W  (BLK_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .nblk     (nblk),
    .busy     (busy),
    .done     (done),
    .msg_valid(msg_valid),
    .msg_ready(msg_ready),
    .msg_data (msg_data),
    .w_valid  (w_valid),
    .w_ready  (w_ready),
    .w_data   (w_data),
    .w_idx    (w_idx),
    .w_last   (w_last),
    .u_run    (u_run),
    .u_running(u_running),
    .u_in0    (u_in0),
    .u_delay0 (u_delay0),
    .u_out0   (u_out0)
  );

  // ---------------- SHA-256 helpers ----------------
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] ss0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] ss1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // ---------------- behavioural xunitM: one window slot per step ----------------
  logic [31:0] uw [64];
  int          ucnt = 0;
  int          overrun = 0;
  always @(posedge clk) begin
    logic [31:0] nw;
    if (rst) begin
      ucnt   <= 0;
      u_out0 <= '0;
    end else if (u_run) begin
      ucnt <= 0;
    end else if (u_running) begin
      if (ucnt >= 64) begin
        overrun <= overrun + 1;
      end else begin
        if (ucnt < 16) nw = u_in0;
        else nw = ss1(uw[ucnt-2]) + uw[ucnt-7] + ss0(uw[ucnt-15]) + uw[ucnt-16];
        uw[ucnt] <= nw;
        u_out0   <= nw;
        ucnt     <= ucnt + 1;
      end
    end
  end

  // ---------------- reference schedule ----------------
  logic [31:0] msgs  [3][16];
  logic [31:0] exp_w [3][64];

  task automatic build_ref();
    for (int b = 0; b < 3; b++)
      for (int t = 0; t < 64; t++)
        exp_w[b][t] = (t < 16) ? msgs[b][t]
                    : ss1(exp_w[b][t-2]) + exp_w[b][t-7] + ss0(exp_w[b][t-15]) + exp_w[b][t-16];
  endtask

  task automatic set_abc(input int b);
    for (int t = 0; t < 16; t++) msgs[b][t] = 32'h0;
    msgs[b][0]  = 32'h61626380;
    msgs[b][15] = 32'h00000018;
  endtask

  task automatic set_random(input int b);
    for (int t = 0; t < 16; t++) msgs[b][t] = $urandom;
  endtask

  // ---------------- monitor (samples on the falling edge) ----------------
  logic [38:0] got [$];  // {w_data, w_idx, w_last} per accepted word
  int mon_cyc = 0, n_urun = 0, n_urunning = 0, n_done = 0, n_busy = 0, n_wvalid = 0;
  int overlap = 0, last_cyc = -1, done_cyc = -1, start_cyc = -1;
  always @(negedge clk) begin
    mon_cyc++;
    if (w_valid && w_ready) got.push_back({w_data, w_idx, w_last});
    if (w_valid && w_ready && w_last) last_cyc = mon_cyc;
    if (w_valid) n_wvalid++;
    if (u_run) n_urun++;
    if (u_running) n_urunning++;
    if (u_run && u_running) overlap++;
    if (done) begin
      n_done++;
      done_cyc = mon_cyc;
    end
    if (busy) n_busy++;
    if (start && !busy && !abort) start_cyc = mon_cyc;
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  int s_q, s_ur, s_ung, s_d, s_busy, s_wv;
  task automatic snap();
    s_q = got.size(); s_ur = n_urun; s_ung = n_urunning;
    s_d = n_done; s_busy = n_busy; s_wv = n_wvalid;
  endtask

  task automatic check_job(input string tag, input int nb);
    int n;
    logic [38:0] e;
    logic lst;
    n = got.size() - s_q;
    chk({tag, "_word_count"}, 64'(n), 64'(nb * 64));
    for (int k = 0; k < n && k < nb * 64; k++) begin
      lst = (k / 64 == nb - 1) && (k % 64 == 63);
      e   = {exp_w[k/64][k%64], 6'(k % 64), lst};
      chk($sformatf("%s_word%0d", tag, k), 64'(got[s_q+k]), 64'(e));
    end
    chk({tag, "_u_running_cycles"}, 64'(n_urunning - s_ung), 64'(nb * 64));
    chk({tag, "_u_run_pulses"}, 64'(n_urun - s_ur), 64'(nb));
    chk({tag, "_done_pulses"}, 64'(n_done - s_d), 64'd1);
    chk({tag, "_done_after_last"}, 64'(done_cyc - last_cyc), 64'd1);
  endtask

  task automatic check_w16_w17(input string tag);
    logic [38:0] r;
    chk({tag, "_w16_present"}, 64'(got.size() - s_q >= 18), 64'd1);
    if (got.size() - s_q >= 18) begin
      r = got[s_q+16];
      chk({tag, "_w16"}, 64'(r[38:7]), 64'h61626380);
      r = got[s_q+17];
      chk({tag, "_w17"}, 64'(r[38:7]), 64'h000F0000);
    end
  endtask

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_stream(input int fed, input int nb, input int rdy_pct);
    if (fed < nb * 16) begin
      msg_valid = ($urandom_range(0, 99) < 75);
      msg_data  = msgs[fed/16][fed%16];
    end else begin
      msg_valid = 1'b0;
      msg_data  = $urandom;
    end
    w_ready = ($urandom_range(0, 99) < rdy_pct);
  endtask

  // Entered just after a rising edge; returns just after the done cycle or after abort.
  task automatic drive(input int nb, input bit do_start, input int fed0, input int rdy_pct,
                       input int abort_idx, output bit aborted);
    int fed, cyc;
    bit trig, ended;
    fed = fed0; cyc = 0; trig = 1'b0; ended = 1'b0; aborted = 1'b0;
    if (do_start) begin
      start = 1'b1;
      nblk  = BLK_W'(nb);
    end
    set_stream(fed, nb, rdy_pct);
    while (cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (abort) begin
        aborted = 1'b1;
        ended   = 1'b1;
        break;
      end
      if (done) begin
        ended = 1'b1;
        break;
      end
      if (msg_valid && msg_ready) fed++;
      if (abort_idx >= 0 && w_valid && w_idx == 6'(abort_idx)) trig = 1'b1;
      @(posedge clk);
      #1;
      start = !trig && ($urandom_range(0, 15) == 0);  // stray starts while busy
      nblk  = BLK_W'($urandom_range(0, 3));
      abort = trig;
      set_stream(fed, nb, rdy_pct);
    end
    if (!ended) chk("job_timeout", 64'd1, 64'd0);
    if (aborted) tick();
    start     = 1'b0;
    abort     = 1'b0;
    msg_valid = 1'b0;
    w_ready   = 1'b0;
  endtask

  typedef struct {
    bit         v;
    bit         r;
    logic [5:0] idx;
    bit         wv;
    bit         mr;
    bit         run;
  } vec_t;
  vec_t tbl [8];

  initial begin
    bit ab;

    // LOAD-phase pass-through vectors: {msg_valid, w_ready, w_idx, w_valid, msg_ready, u_running}
    tbl[0] = '{1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 6'd0, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 6'd0, 1'b1, 1'b1, 1'b1};
    tbl[4] = '{1'b1, 1'b1, 6'd1, 1'b1, 1'b1, 1'b1};
    tbl[5] = '{1'b1, 1'b0, 6'd2, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 6'd2, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 6'd2, 1'b1, 1'b1, 1'b1};

    rst = 1'b1; start = 1'b0; abort = 1'b0; nblk = '0;
    msg_valid = 1'b0; msg_data = '0; w_ready = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("reset_outputs", 64'({busy, done, msg_ready, w_valid, w_last, u_run, u_running, w_idx}),
        64'd0);
    tick();
    rst = 1'b0;
    tick();

    // 1: "abc" block, downstream always ready
    set_abc(0); build_ref(); snap();
    drive(1, 1'b1, 0, 100, -1, ab);
    tick();
    check_job("abc", 1);
    check_w16_w17("abc");

    // 2: same block, random backpressure
    snap();
    drive(1, 1'b1, 0, 50, -1, ab);
    tick();
    check_job("abc_bp", 1);

    // LOAD pass-through table on a random block, then finish it randomly
    set_random(0); build_ref(); snap();
    start = 1'b1; nblk = BLK_W'(1);
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("arm_outputs", 64'({u_run, u_running, busy, msg_ready, w_valid}), 64'b10100);
    tick();
    for (int k = 0; k < 8; k++) begin
      msg_valid = tbl[k].v;
      w_ready   = tbl[k].r;
      msg_data  = msgs[0][tbl[k].idx];
      @(negedge clk);
      chk($sformatf("load_ctl_row%0d", k),
          64'({w_valid, msg_ready, u_running, u_run, busy, w_idx}),
          64'({tbl[k].wv, tbl[k].mr, tbl[k].run, 1'b0, 1'b1, tbl[k].idx}));
      chk($sformatf("load_data_row%0d", k), {w_data, u_in0},
          {msgs[0][tbl[k].idx], msgs[0][tbl[k].idx]});
      tick();
    end
    drive(1, 1'b0, 3, 60, -1, ab);
    tick();
    check_job("table", 1);

    // 3: three back-to-back random blocks (w_idx wraps twice)
    for (int b = 0; b < 3; b++) set_random(b);
    build_ref(); snap();
    drive(3, 1'b1, 0, 70, -1, ab);
    tick();
    check_job("three_blk", 3);

    // 4: empty job: FIN right after the start edge, busy for that cycle only
    snap();
    drive(0, 1'b1, 0, 100, -1, ab);
    tick();
    chk("nblk0_words", 64'(got.size() - s_q), 64'd0);
    chk("nblk0_w_valid_cycles", 64'(n_wvalid - s_wv), 64'd0);
    chk("nblk0_done_pulses", 64'(n_done - s_d), 64'd1);
    chk("nblk0_busy_cycles", 64'(n_busy - s_busy), 64'd1);
    chk("nblk0_done_latency", 64'(done_cyc - start_cyc), 64'd1);

    // 5: abort at W[40], then a clean "abc" job
    set_abc(0); build_ref(); snap();
    drive(1, 1'b1, 0, 80, 40, ab);
    chk("abort_taken", 64'(ab), 64'd1);
    @(negedge clk);
    chk("abort_idle", 64'({busy, done, msg_ready, w_valid, w_last, u_run, u_running, w_idx}), 64'd0);
    tick();
    chk("abort_no_done", 64'(n_done - s_d), 64'd0);
    snap();
    drive(1, 1'b1, 0, 100, -1, ab);
    tick();
    check_job("post_abort", 1);
    check_w16_w17("post_abort");

    // start and abort together in IDLE: abort wins
    start = 1'b1; abort = 1'b1; nblk = BLK_W'(2);
    tick();
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("start_abort_same_cycle", 64'({busy, u_run}), 64'd0);
    tick();

    // 6: reset mid-LOAD at t=7, then a restarted job
    set_abc(0); build_ref();
    start = 1'b1; nblk = BLK_W'(1);
    tick();
    start = 1'b0;
    tick();
    for (int i = 0; i < 7; i++) begin
      msg_valid = 1'b1; msg_data = msgs[0][i]; w_ready = 1'b1;
      tick();
    end
    @(negedge clk);
    chk("pre_rst_load_idx", 64'({busy, w_idx}), 64'({1'b1, 6'd7}));
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    rst = 1'b0; msg_valid = 1'b0; w_ready = 1'b0;
    @(negedge clk);
    chk("mid_load_reset", 64'({busy, done, msg_ready, w_valid, w_last, u_run, u_running, w_idx}),
        64'd0);
    tick();
    snap();
    drive(1, 1'b1, 0, 50, -1, ab);
    tick();
    check_job("post_rst", 1);
    check_w16_w17("post_rst");

    chk("run_running_overlap", 64'(overlap), 64'd0);
    chk("unit_overrun", 64'(overrun), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
